bin_to_sseg: RTL and testbench

- Sequential upstream feeder for the 4-digit seven-segment display multiplexer.
- Accepts a 14-bit unsigned binary value through a start/ready handshake.
- Converts it to four BCD digits using shift-and-add-3 (double dabble), one bit per clock.
- Encodes each digit to an active-low 8-bit segment pattern and holds the four patterns stable on in0..in3 until the next conversion completes.

---
 rtl/bin_to_sseg.sv | 129 ++++++++++++
 tb/tb_bin_to_sseg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_sseg.sv
// Sequential 14-bit binary to 4-digit seven-segment pattern converter (double dabble, one bit per clock).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bin_to_sseg #(
    parameter logic [3:0] DP_MASK = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        ready,
    output logic        done,
    output logic        ovf,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_ENC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [13:0] r_shift;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf_next;

    logic [15:0] w_bcd_adj;
    logic [6:0]  w_seg [4];

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Returns g..a, active-low; non-decimal nibbles render blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_bcd_adj = add3(r_bcd);

    always_comb begin
        for (int i = 0; i < 4; i++) w_seg[i] = seg7(r_bcd[i*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_bcd[15:12] == 4'd0) w_seg[3] = 7'b1111111;
        if (r_bcd[15:8]  == 8'd0) w_seg[2] = 7'b1111111;
        if (r_bcd[15:4]  == 12'd0) w_seg[1] = 7'b1111111;
`else
`endif
        // Overflow dashes win over digits and blanking alike.
        if (r_ovf_next) begin
            for (int i = 0; i < 4; i++) w_seg[i] = 7'b0111111;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            ovf        <= 1'b0;
            in0        <= 8'hFF;
            in1        <= 8'hFF;
            in2        <= 8'hFF;
            in3        <= 8'hFF;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift    <= bin;
                        r_bcd      <= '0;
                        r_cnt      <= 4'd14;
                        r_ovf_next <= (bin > 14'd9999);
                        ready      <= 1'b0;
                        r_state    <= S_OP;
                    end
                end
                S_OP: begin
                    r_bcd   <= {w_bcd_adj[14:0], r_shift[13]};
                    r_shift <= {r_shift[12:0], 1'b0};
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_ENC;
                end
                S_ENC: begin
                    in0     <= {~DP_MASK[0], w_seg[0]};
                    in1     <= {~DP_MASK[1], w_seg[1]};
                    in2     <= {~DP_MASK[2], w_seg[2]};
                    in3     <= {~DP_MASK[3], w_seg[3]};
                    ovf     <= r_ovf_next;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_sseg.sv
// Bench for bin_to_sseg: two instances (DP_MASK 0 and 4'b0100) checked against a decimal-arithmetic model.
module tb_bin_to_sseg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        ready, done, ovf;
    logic [7:0]  in0, in1, in2, in3;
    logic        ready2, done2, ovf2;
    logic [7:0]  p0, p1, p2, p3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin_to_sseg #(.DP_MASK(4'b0000)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(ready), .done(done), .ovf(ovf),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3)
    );

    bin_to_sseg #(.DP_MASK(4'b0100)) dut_dp (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(ready2), .done(done2), .ovf(ovf2),
        .in0(p0), .in1(p1), .in2(p2), .in3(p3)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected {in3,in2,in1,in0} from decimal digits of v.
    function automatic logic [31:0] model(input int v, input logic [3:0] m);
        logic [31:0] r;
        logic [6:0]  s;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999) s = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
            else if (i > 0 && v < p) s = 7'b1111111;
`endif
            else s = seg_of((v / p) % 10);
            r[i*8 +: 8] = {~m[i], s};
            p = p * 10;
        end
        return r;
    endfunction

    // Drives one conversion starting at a negedge; returns edges from accept to done (0 = timeout).
    task automatic run_conv(input int v, output int lat);
        start = 1'b1;
        bin   = 14'(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom_range(0, 16383));
        lat   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int v, input int lat);
        logic [31:0] e0, e1;
        e0 = model(v, 4'b0000);
        e1 = model(v, 4'b0100);
        tests++;
        if (lat !== 15) begin
            fails++; $display("FAIL %s latency: got %0d want 15", name, lat);
        end
        tests++;
        if ({in3, in2, in1, in0} !== e0) begin
            fails++; $display("FAIL %s segs v=%0d: got %h want %h", name, v, {in3, in2, in1, in0}, e0);
        end
        tests++;
        if ({p3, p2, p1, p0} !== e1) begin
            fails++; $display("FAIL %s dp segs v=%0d: got %h want %h", name, v, {p3, p2, p1, p0}, e1);
        end
        tests++;
        if (ovf !== (v > 9999) || ovf2 !== (v > 9999)) begin
            fails++; $display("FAIL %s ovf v=%0d: got %b/%b want %b", name, v, ovf, ovf2, v > 9999);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({in3, in2, in1, in0, p3, p2, p1, p0} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++; $display("FAIL reset segs: got %h %h want all FF", {in3, in2, in1, in0}, {p3, p2, p1, p0});
        end
        tests++;
        if ({ready, done, ovf} !== 3'b100) begin
            fails++; $display("FAIL reset flags rdy/done/ovf: got %b want 100", {ready, done, ovf});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                fails++; $display("FAIL idle no-start: done=%b ready=%b want 0/1", done, ready);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] held;
        run_conv(1234, lat);
        check_result("basic1234", 1234, lat);
        tests++;
        if ({in3, in2, in1, in0} !== 32'hF9A4B099) begin
            fails++; $display("FAIL basic1234 const: got %h want F9A4B099", {in3, in2, in1, in0});
        end
        held = {in3, in2, in1, in0};
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || {in3, in2, in1, in0} !== held) begin
            fails++; $display("FAIL done pulse/hold: done=%b segs=%h want 0/%h", done, {in3, in2, in1, in0}, held);
        end
    endtask

    task automatic test_boundary();
        int lat;
        run_conv(9999, lat);
        check_result("b9999", 9999, lat);
        tests++;
        if ({in3, in2, in1, in0, ovf} !== {32'h90909090, 1'b0}) begin
            fails++; $display("FAIL b9999 const: got %h ovf=%b want 90909090 0", {in3, in2, in1, in0}, ovf);
        end
        run_conv(10000, lat);
        check_result("b10000", 10000, lat);
        tests++;
        if ({in3, in2, in1, in0, ovf} !== {32'hBFBFBFBF, 1'b1}) begin
            fails++; $display("FAIL b10000 const: got %h ovf=%b want BFBFBFBF 1", {in3, in2, in1, in0}, ovf);
        end
        run_conv(16383, lat);
        check_result("b16383", 16383, lat);
    endtask

    task automatic test_small();
        int lat;
        logic [31:0] e42, e0;
`ifdef LEADING_ZERO_BLANK_EN
        e42 = 32'hFFFF99A4;
        e0  = 32'hFFFFFFC0;
`else
        e42 = 32'hC0C099A4;
        e0  = 32'hC0C0C0C0;
`endif
        run_conv(42, lat);
        check_result("s42", 42, lat);
        tests++;
        if ({in3, in2, in1, in0} !== e42) begin
            fails++; $display("FAIL s42 const: got %h want %h", {in3, in2, in1, in0}, e42);
        end
        run_conv(0, lat);
        check_result("s0", 0, lat);
        tests++;
        if ({in3, in2, in1, in0} !== e0) begin
            fails++; $display("FAIL s0 const: got %h want %h", {in3, in2, in1, in0}, e0);
        end
    endtask

    task automatic test_random();
        int lat, v;
        for (int n = 0; n < 24; n++) begin
            case (n % 4)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 9999);
                2: v = $urandom_range(10000, 16383);
                default: v = $urandom_range(0, 16383);
            endcase
            run_conv(v, lat);
            check_result("rand", v, lat);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int last, v, got;
        last = -1;
        got  = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL b2b unexpected done at cycle %0d", cyc);
                end else begin
                    v = q.pop_front();
                    got++;
                    check_result("b2b", v, 15);
                end
            end
            bin = 14'($urandom_range(0, 16383));
            if (ready) begin
                q.push_back(int'(bin));
                if (last >= 0) begin
                    tests++;
                    if (cyc - last !== 16) begin
                        fails++; $display("FAIL b2b accept spacing: got %0d want 16", cyc - last);
                    end
                end
                last = cyc;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            if (done) begin
                v = q.pop_front();
                got++;
                check_result("b2b", v, 15);
            end
            @(negedge clk);
        end
        tests++;
        if (q.size() !== 0 || got < 11) begin
            fails++; $display("FAIL b2b drain: pending=%0d completed=%0d want 0/>=11", q.size(), got);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        start = 1'b1;
        bin   = 14'd5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({in3, in2, in1, in0, p3, p2, p1, p0} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++; $display("FAIL midreset segs: got %h %h want all FF", {in3, in2, in1, in0}, {p3, p2, p1, p0});
        end
        tests++;
        if ({ready, done, ovf} !== 3'b100) begin
            fails++; $display("FAIL midreset flags rdy/done/ovf: got %b want 100", {ready, done, ovf});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0) begin
                fails++; $display("FAIL midreset stray done at %0d: got 1 want 0", k);
            end
        end
        run_conv(5678, lat);
        check_result("after_reset5678", 5678, lat);
        tests++;
        if (p2[7] !== 1'b0 || {p3[7], p1[7], p0[7]} !== 3'b111) begin
            fails++; $display("FAIL dp mask bits: got %b%b%b%b want 1011", p3[7], p2[7], p1[7], p0[7]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_small();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
